seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_ctrl_if.sv | 24 ++
 rtl/seg7_prescaler.sv | 29 ++
 rtl/seg7_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Provides digit geometry, the slot state type and a one-hot helper.
package seg7_pkg;

  localparam int N_DIGITS_DEFAULT = 4;
  localparam int NIB_W            = 4;
  localparam int MAX_DIGITS       = 32;

  typedef enum logic {
    SLOT_DEAD,
    SLOT_ON
  } slot_state_t;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Valid/ready load port carrying a full display value into the scan controller.
// The source drives the master side and the controller consumes the slave side.
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = seg7_pkg::N_DIGITS_DEFAULT
);
  import seg7_pkg::*;

  logic                      load_valid;
  logic                      load_ready;
  logic [NIB_W*N_DIGITS-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/seg7_prescaler.sv
// Free-running modulo-PRESCALE counter with a terminal-count strobe.
// Reusable as a time base for any slot-based peripheral.
module seg7_prescaler #(
  parameter  int PRESCALE = 100000,
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg7_prescaler: PRESCALE must be at least 2");
  end

  assign tick = (cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: slot timing with a blanked dead
// interval, frame-aligned double buffering, per-digit enable and zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int N_DIGITS = N_DIGITS_DEFAULT,
  parameter  int PRESCALE = 100000,
  parameter  int DEAD     = 16,
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int DATA_W   = NIB_W * N_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_ctrl_if.slave     load,
  input  logic [N_DIGITS-1:0] en_mask,
  input  logic                lz_suppress,
  output logic [N_DIGITS-1:0] an,
  output logic [NIB_W-1:0]    nibble,
  output logic                blank,
  output logic                frame_start
);

  if (DEAD >= PRESCALE) begin : g_bad_dead
    $error("seg7_scan_ctrl: DEAD must be smaller than PRESCALE");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                tick;
  logic [IDX_W-1:0]    idx;
  slot_state_t         state;
  logic [DATA_W-1:0]   active;
  logic [DATA_W-1:0]   pending;
  logic                pend_flag;
  logic [N_DIGITS-1:0] en_q;
  logic                lz_q;
  logic                boundary;
  logic                accept;
  logic [NIB_W-1:0]    digits     [N_DIGITS];
  logic [N_DIGITS-1:0] suppressed;
  logic [N_DIGITS-1:0] sel;
  logic                lit;
  logic                zero_run;

  seg7_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign cnt_next = tick ? '0 : cnt + CNT_W'(1);
  assign boundary = tick && (idx == LAST_IDX);
  assign accept   = load.load_valid && !pend_flag;

  // Slot sequencing: the dead window is tracked against the counter value the
  // next cycle will see, so the state register lines up exactly with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_DEAD;
      idx   <= '0;
      en_q  <= '0;
      lz_q  <= 1'b0;
    end else begin
      case (state)
        SLOT_DEAD: begin
          if (cnt_next >= CNT_W'(DEAD)) begin
            state <= SLOT_ON;
          end
        end
        SLOT_ON: begin
          if (tick && (DEAD != 0)) begin
            state <= SLOT_DEAD;
          end
        end
        default: state <= SLOT_DEAD;
      endcase

      if (tick) begin
        idx  <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        en_q <= en_mask;
        lz_q <= lz_suppress;
      end
    end
  end

  // A value accepted on the boundary cycle lands in pending only; active
  // takes pending solely when something was already waiting there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (boundary && pend_flag) begin
        active <= pending;
      end
      if (accept) begin
        pending   <= load.load_data;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    zero_run = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      digits[i]     = active[NIB_W*(N_DIGITS-1-i) +: NIB_W];
      zero_run      = zero_run && (digits[i] == '0);
      suppressed[i] = lz_q && (i < N_DIGITS - 1) && zero_run;
    end
  end

  always_comb begin
    sel = N_DIGITS'(onehot(32'(idx)));
    lit = (state == SLOT_ON) && en_q[idx] && !suppressed[idx];
    an  = lit ? sel : '0;
  end

  assign nibble          = digits[idx];
  assign blank           = (an == '0);
  assign frame_start     = (idx == '0) && (cnt == '0);
  assign load.load_ready = !pend_flag;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a cycle-indexed reference model.
// Directed test-plan phases are followed by randomized load/mask traffic.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int PRE   = 8;
  localparam int DT    = 2;
  localparam int FRAME = PRE * ND;

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] en_mask;
  logic          lz_suppress;
  logic [ND-1:0] an;
  logic [3:0]    nibble;
  logic          blank;
  logic          frame_start;

  seg7_scan_ctrl_if #(.N_DIGITS(ND)) load_bus ();

  seg7_scan_ctrl #(
    .N_DIGITS (ND),
    .PRESCALE (PRE),
    .DEAD     (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_bus),
    .en_mask     (en_mask),
    .lz_suppress (lz_suppress),
    .an          (an),
    .nibble      (nibble),
    .blank       (blank),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_has;
  logic [3:0]  m_en;
  bit          m_lz;
  bit          src_valid;
  logic [15:0] src_data;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, t, observed, expected);
    end
  endtask

  function automatic logic [15:0] genData();
    logic [15:0] v;
    int          zeros;
    v     = 16'($urandom);
    zeros = $urandom_range(0, 4);
    if (zeros == 4) v = 16'h0000;
    else            v = v & (16'hFFFF >> (4 * zeros));
    if ($urandom_range(0, 3) == 0) v[7:4] = 4'h0;
    return v;
  endfunction

  function automatic void modelReset();
    t         = 0;
    m_active  = '0;
    m_pending = '0;
    m_has     = 0;
    m_en      = '0;
    m_lz      = 0;
  endfunction

  // Expected outputs follow from the cycle number alone: slot = t/PRE,
  // digit = slot mod ND, and a digit is lit once DT cycles into its slot.
  task automatic checkModel();
    int         d;
    int         pos;
    bit         supp;
    logic [3:0] exp_an;
    logic [3:0] exp_nib;
    d       = (t / PRE) % ND;
    pos     = t % PRE;
    supp    = m_lz && (d < ND - 1) && ((m_active >> (4 * (ND - 1 - d))) == 16'h0);
    exp_nib = 4'((m_active >> (4 * (ND - 1 - d))) & 16'hF);
    exp_an  = (pos >= DT && m_en[d] && !supp) ? (4'b0001 << d) : 4'b0000;
    checkOutput("an", 32'(an), 32'(exp_an));
    checkOutput("blank", 32'(blank), 32'(exp_an == 4'b0000));
    checkOutput("nibble", 32'(nibble), 32'(exp_nib));
    checkOutput("frame_start", 32'(frame_start), 32'((t % FRAME) == 0));
    checkOutput("load_ready", 32'(load_bus.load_ready), 32'(!m_has));
  endtask

  function automatic void modelStep();
    bit acc;
    acc = src_valid && !m_has;
    if ((t % FRAME) == FRAME - 1 && m_has) begin
      m_active = m_pending;
      m_has    = 0;
    end
    if (acc) begin
      m_pending = src_data;
      m_has     = 1;
      src_valid = 0;
    end
    if ((t % PRE) == PRE - 1) begin
      m_en = en_mask;
      m_lz = lz_suppress;
    end
    t++;
  endfunction

  // mode 0: load/back-pressure/mask plan, mode 1: zero blanking, mode 2: random
  task automatic applyStimulus(input int mode);
    case (mode)
      0: begin
        en_mask     = (t >= 36) ? 4'b1110 : 4'hF;
        lz_suppress = 1'b0;
        if (t == 3)      begin src_valid = 1; src_data = 16'h0D8C; end
        else if (t == 5) begin src_valid = 1; src_data = 16'h1234; end
      end
      1: begin
        en_mask     = 4'hF;
        lz_suppress = 1'b1;
        if (t == 1)       begin src_valid = 1; src_data = 16'h000C; end
        else if (t == 40) begin src_valid = 1; src_data = 16'h0000; end
        else if (t == 72) begin src_valid = 1; src_data = 16'h0D0C; end
      end
      default: begin
        if (!src_valid && $urandom_range(0, 5) == 0) begin
          src_valid = 1;
          src_data  = genData();
        end
        if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom);
        if ($urandom_range(0, 29) == 0) lz_suppress = ~lz_suppress;
      end
    endcase
    load_bus.load_valid = src_valid;
    load_bus.load_data  = src_data;
  endtask

  // Entered at a falling edge; leaves at a falling edge.
  task automatic runCycles(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      applyStimulus(mode);
      checkModel();
      @(posedge clk);
      modelStep();
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst_n               = 1'b0;
    src_valid           = 0;
    load_bus.load_valid = 1'b0;
    #1;
    checkOutput("rst_an", 32'(an), 32'h0);
    checkOutput("rst_blank", 32'(blank), 32'h1);
    checkOutput("rst_nibble", 32'(nibble), 32'h0);
    checkOutput("rst_load_ready", 32'(load_bus.load_ready), 32'h1);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    rst_n               = 1'b0;
    en_mask             = 4'h0;
    lz_suppress         = 1'b0;
    src_valid           = 0;
    src_data            = '0;
    load_bus.load_valid = 1'b0;
    load_bus.load_data  = '0;
    modelReset();
    @(negedge clk);
    doReset();

    runCycles(45, 0);
    doReset();
    runCycles(130, 1);
    doReset();
    for (int r = 0; r < 4; r++) begin
      runCycles($urandom_range(150, 400), 2);
      doReset();
    end
    runCycles(64, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
